ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Sequential initiator for the single-port model RAM (16 x 8, select/write strobes). It drives the memory interface that the model memory responds to.
- On a start pulse it runs two passes:
  - Write pass: fills every location with the deterministic pattern data = (2*addr) mod 2^DW.
  - Read pass: reads back NUM_READS pseudo-random addresses from an LFSR and checks each word against the pattern.
- Reports pass/fail, a saturating error count and the first failing address. Every checked read is also exposed on an observation port for logging.

Parameters:
- AW, 4, address width; DEPTH = 2^AW; supported range 4..8.
- DW, 8, data width.
- NUM_READS, 20, number of read-check transactions per run; range 1..255.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- seed  in  AW  LFSR seed, captured when start is accepted.
- mem_addr  out  AW  RAM address.
- mem_din  out  DW  RAM write data.
- mem_wr  out  1  1 = write, 0 = read; meaningful only while mem_sel = 1.
- mem_sel  out  1  RAM select, active-high.
- mem_dout  in  DW  RAM read data; must be valid one clock after address/sel are presented.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done onward: 1 if err_cnt == 0; held until the next start.
- err_cnt  out  8  mismatch count, saturates at 255.
- first_err_addr  out  AW  address of the first mismatch; 0 if none.
- obs_valid  out  1  pulse per checked read.
- obs_addr  out  AW  address of the checked read.
- obs_data  out  DW  data returned by the RAM for that read.

Behaviour:
- Reset (synchronous, wins over everything):
  - State = IDLE; all outputs = 0; LFSR = 1.
  - Mid-run reset aborts the run. mem_sel/mem_wr are 0 from the cycle after the reset edge. No done pulse is issued.
- Start:
  - In IDLE, start = 1 at an edge moves the FSM to WRITE. err_cnt, first_err_addr and pass are cleared.
  - LFSR is loaded with seed; seed == 0 is replaced by 1.
  - start is ignored in every other state.
- WRITE (DEPTH cycles):
  - Each cycle: mem_sel = 1, mem_wr = 1, mem_addr = k, mem_din = (2k) mod 2^DW, for k = 0..DEPTH-1.
  - After k = DEPTH-1, go to READ.
- READ (NUM_READS cycles):
  - Each cycle: mem_sel = 1, mem_wr = 0, mem_addr = LFSR value; then the LFSR advances.
  - The first read address is the seed itself.
  - One-stage pipeline: the address presented in cycle n is checked in cycle n+1 against mem_dout.
- CHK (1 cycle):
  - mem_sel = 0; checks the final read.
- DONE (1 cycle):
  - done = 1, busy = 0, pass updated; return to IDLE.
- Timing:
  - busy rises in the first WRITE cycle.
  - done is asserted exactly DEPTH + NUM_READS + 1 cycles after the first WRITE cycle (37 with defaults).
- Check rule (every read):
  - obs_valid = 1, obs_addr = checked address, obs_data = mem_dout.
  - On mismatch, err_cnt increments, saturating at 255.
  - first_err_addr is captured only when err_cnt was 0.
- LFSR:
  - Fibonacci form: next = {q[AW-2:0], q[AW-1] ^ q[tap]}, with taps from the package (AW = 4: x^4+x^3+1).
  - Never reaches 0, so address 0 is never read-checked. This is intended and documented.
- Outside READ/WRITE: mem_addr, mem_din and mem_wr hold 0.

Decomposition:
- Package ram_bist_pkg:
  - State enum {IDLE, WRITE, READ, CHK, DONE}.
  - LFSR tap table indexed by AW (4..8).
  - Pattern function pat(addr) = (2*addr) mod 2^DW.
- Sub-module lfsr_gen (AW):
  - Inputs: load, seed, advance. Output: q.
  - Contains the zero-seed substitution.
- The FSM, pipeline register and checker stay in ram_bist_ctrl.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles, start = 0 -> all outputs 0, mem_sel = 0 indefinitely.
- Clean run, seed = 4'h1, good RAM model:
  - Writes: (0,0), (1,2), ..., (15,30).
  - Read addresses: 1, 2, 4, 9, 3, 6, 13, 10, 5, 11, ...
  - obs_data: 2, 4, 8, 18, 6, 12, ...
  - done at cycle 37; pass = 1; err_cnt = 0.
- Fault: RAM model forces location 9 to read 0x00, seed = 1 -> err_cnt = count of reads of address 9 (>= 1), first_err_addr = 9, pass = 0.
- Seed = 0 -> behaves identically to seed = 1 (first read address 1).
- start pulsed during WRITE -> ignored; single done at cycle 37; no restart.
- rst asserted at READ cycle 5 -> mem_sel = 0 next cycle, no done, outputs 0. A following start runs a full clean pass.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST controller: FSM states,
// LFSR feedback masks and the write/check data pattern.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4
    } bist_state_e;

    // Feedback mask: bit i set means q[i] feeds the XOR; the MSB is always set.
    function automatic logic [7:0] lfsr_taps(input logic [3:0] aw);
        logic [7:0] mask;
        case (aw)
            4'd4:    mask = 8'h0C;
            4'd5:    mask = 8'h14;
            4'd6:    mask = 8'h30;
            4'd7:    mask = 8'h60;
            4'd8:    mask = 8'hB8;
            default: mask = 8'h0C;
        endcase
        return mask;
    endfunction

    // Pattern word for an address; callers truncate to their data width.
    function automatic logic [15:0] pat(input logic [7:0] addr);
        return {7'd0, addr, 1'b0};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR used as the read-address generator; a zero seed is
// replaced by 1 so the register can never lock up at 0.
module lfsr_gen
    import ram_bist_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] seed,
    input  logic          advance,
    output logic [AW-1:0] q
);

    localparam logic [AW-1:0] TAP_MASK = AW'(lfsr_taps(4'(AW)));

    logic [AW-1:0] q_q;
    logic [AW-1:0] q_d;

    // Next-state: load has priority over advance.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (seed == '0) ? AW'(1'b1) : seed;
        end else if (advance) begin
            q_d = {q_q[AW-2:0], ^(q_q & TAP_MASK)};
        end else begin
            q_d = q_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= AW'(1'b1);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: writes the address pattern to every location, then
// read-checks NUM_READS LFSR-chosen addresses with a one-stage pipeline.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int NUM_READS = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] seed,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wr,
    output logic          mem_sel,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic          obs_valid,
    output logic [AW-1:0] obs_addr,
    output logic [DW-1:0] obs_data
);

    localparam int         DEPTH   = 1 << AW;
    localparam logic [7:0] LAST_WR = 8'(DEPTH - 1);
    localparam logic [7:0] LAST_RD = 8'(NUM_READS - 1);

    bist_state_e   state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] lfsr_q;
    logic          start_acc;
    logic          lfsr_adv;
    logic          rd_mismatch;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_wr_q, mem_wr_d, mem_sel_q, mem_sel_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0] first_err_q, first_err_d;
    logic          obs_valid_q, obs_valid_d;
    logic [AW-1:0] obs_addr_q, obs_addr_d;
    logic [DW-1:0] obs_data_q, obs_data_d;
    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    assign start_acc = (state_q == IDLE) && start;

    lfsr_gen #(.AW(AW)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_acc),
        .seed    (seed),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    // FSM next state and phase counter (write address / read index).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (cnt_q == LAST_WR) begin
                    state_d = READ;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            READ: begin
                if (cnt_q == LAST_RD) begin
                    state_d = CHK;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CHK:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Memory-side outputs are registered, so they are decoded from next state.
    always_comb begin
        mem_sel_d  = (state_d == WRITE) || (state_d == READ);
        mem_wr_d   = (state_d == WRITE);
        busy_d     = (state_d == WRITE) || (state_d == READ) || (state_d == CHK);
        done_d     = (state_d == DONE);
        lfsr_adv   = (state_d == READ);
        mem_addr_d = '0;
        mem_din_d  = '0;
        if (state_d == WRITE) begin
            mem_addr_d = cnt_d[AW-1:0];
            mem_din_d  = DW'(pat(cnt_d));
        end else if (state_d == READ) begin
            mem_addr_d = lfsr_q;
        end else begin
            mem_addr_d = '0;
        end
    end

    // Read pipeline and checker: a read presented last cycle is compared now.
    always_comb begin
        rd_pend_d   = mem_sel_q && !mem_wr_q;
        rd_addr_d   = mem_addr_q;
        rd_mismatch = rd_pend_q && (mem_dout != DW'(pat(8'(rd_addr_q))));
        obs_valid_d = rd_pend_q;
        obs_addr_d  = rd_pend_q ? rd_addr_q : '0;
        obs_data_d  = rd_pend_q ? mem_dout : '0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        if (start_acc) begin
            err_cnt_d   = 8'd0;
            first_err_d = '0;
            pass_d      = 1'b0;
        end else if (rd_mismatch) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == 8'd0) begin
                first_err_d = rd_addr_q;
            end else begin
                first_err_d = first_err_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end
        if (state_d == DONE) begin
            pass_d = (err_cnt_d == 8'd0);
        end else begin
            pass_d = pass_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wr_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
            first_err_q <= '0;
            obs_valid_q <= 1'b0;
            obs_addr_q  <= '0;
            obs_data_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_wr_q    <= mem_wr_d;
            mem_sel_q   <= mem_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            obs_valid_q <= obs_valid_d;
            obs_addr_q  <= obs_addr_d;
            obs_data_q  <= obs_data_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_wr         = mem_wr_q;
    assign mem_sel        = mem_sel_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign obs_valid      = obs_valid_q;
    assign obs_addr       = obs_addr_q;
    assign obs_data       = obs_data_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 16x8 RAM model and an obs scoreboard.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] seed = 4'd0;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_wr;
    logic       mem_sel;
    logic [7:0] mem_dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [3:0] first_err_addr;
    logic       obs_valid;
    logic [3:0] obs_addr;
    logic [7:0] obs_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected LFSR read-address cycle for x^4+x^3+1 starting at 1.
    int unsigned seq_tab [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    logic [11:0] sb [$];

    logic [7:0] ram [16];
    logic [7:0] dout_r = 8'd0;
    bit         fault = 1'b0;

    always #5 clk = ~clk;

    // Single-port RAM model with registered read and an optional stuck-at-0 word.
    always @(posedge clk) begin
        if (mem_sel) begin
            if (mem_wr) ram[mem_addr] <= mem_din;
            else dout_r <= (fault && mem_addr == 4'd9) ? 8'h00 : ram[mem_addr];
        end
    end
    assign mem_dout = dout_r;

    ram_bist_ctrl #(.AW(4), .DW(8), .NUM_READS(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .seed           (seed),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_wr         (mem_wr),
        .mem_sel        (mem_sel),
        .mem_dout       (mem_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .obs_valid      (obs_valid),
        .obs_addr       (obs_addr),
        .obs_data       (obs_data)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({mem_sel, mem_wr, mem_addr, mem_din, busy, done, pass, err_cnt,
                    first_err_addr, obs_valid, obs_addr, obs_data});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One BIST run; c = 0 is the first WRITE cycle. rst_at >= 0 aborts at that read index.
    task automatic run_bist(input logic [3:0] sd, input bit flt, input bit poke, input int rst_at);
        int          idx;
        int          done_cnt;
        int          obs_cnt;
        int          exp_err;
        logic [3:0]  exp_first;
        logic [3:0]  a;
        logic [7:0]  ed;
        logic [11:0] e;
        fault     = flt;
        idx       = 0;
        for (int i = 0; i < 15; i++)
            if (seq_tab[i] == ((sd == 4'd0) ? 32'd1 : 32'(sd))) idx = i;
        done_cnt  = 0;
        obs_cnt   = 0;
        exp_err   = 0;
        exp_first = 4'd0;
        sb.delete();
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c < 16) begin
                check("wr_ctl", 64'({mem_sel, mem_wr}), 64'(2'b11));
                check("wr_addr", 64'(mem_addr), 64'(c));
                check("wr_din", 64'(mem_din), 64'(2 * c));
            end else if (c < 36) begin
                a   = 4'(seq_tab[idx]);
                idx = (idx + 1) % 15;
                ed  = (flt && a == 4'd9) ? 8'h00 : 8'({a, 1'b0});
                check("rd_ctl", 64'({mem_sel, mem_wr}), 64'(2'b10));
                check("rd_addr", 64'(mem_addr), 64'(a));
                sb.push_back({a, ed});
                if (ed != 8'({a, 1'b0})) begin
                    if (exp_err == 0) exp_first = a;
                    exp_err++;
                end
            end else begin
                check("idle_mem", 64'({mem_sel, mem_wr, mem_addr, mem_din}), 64'd0);
            end
            check("busy", 64'(busy), 64'(c < 37));
            if (obs_valid) begin
                obs_cnt++;
                if (sb.size() == 0) begin
                    check("obs_extra", 64'(obs_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("obs", 64'({obs_addr, obs_data}), 64'(e));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", 64'(c), 64'd37);
                check("pass_at_done", 64'(pass), 64'(exp_err == 0));
                check("err_cnt", 64'(err_cnt), 64'(exp_err));
                check("first_err", 64'(first_err_addr), 64'(exp_first));
            end
            if (poke && c == 5) start = 1'b1;
            if (poke && c == 6) start = 1'b0;
            if (rst_at >= 0 && c == 16 + rst_at) begin
                rst = 1'b1;
                tick();
                check("abort_outs", all_outs(), 64'd0);
                rst = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    tick();
                    check("abort_quiet", 64'({done, busy, mem_sel}), 64'd0);
                end
                return;
            end
            tick();
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("obs_count", 64'(obs_cnt), 64'd20);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("pass_held", 64'(pass), 64'(exp_err == 0));
        check("err_held", 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("reset_idle", all_outs(), 64'd0);
            tick();
        end

        run_bist(4'h1, 1'b0, 1'b0, -1);
        run_bist(4'h1, 1'b1, 1'b0, -1);
        run_bist(4'h0, 1'b0, 1'b0, -1);
        run_bist(4'hA, 1'b0, 1'b0, -1);
        run_bist(4'h1, 1'b0, 1'b1, -1);
        run_bist(4'h1, 1'b0, 1'b0, 5);
        run_bist(4'h3, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
